// File: rtl/muldiv_ctrl_if.sv
// Signal bundle between the EXE stage / multiply-divide IPs and muldiv_ctrl.
//
// Handshake semantics, in one place:
//   - Request: exe_valid with op_mult/op_div starts an operation only when the
//     controller is idle and flush is low. md_busy is the stall back to EXE.
//     The request must be held while md_busy is high.
//   - Result: md_done stays high with hi_out/lo_out stable until accept is
//     seen on a rising clk edge. That edge retires the result.
//   - Divider IP: div_in_valid is a one-cycle operand-valid pulse. The IP
//     returns exactly one div_dout_valid pulse per operand pulse. Quotient and
//     remainder are valid in that same cycle.
//   - Multiplier IP: mul_product is valid MULT_LAT cycles after mul_a/mul_b
//     change. The operands are held stable until the next start.
interface muldiv_ctrl_if;
    // EXE-stage request side
    logic        exe_valid;
    logic        op_mult;
    logic        op_div;
    logic        op_unsigned;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        accept;

    // Multiplier / divider IP results
    logic [63:0] mul_product;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_dout_valid;

    // Registered operands towards the IPs
    logic [32:0] mul_a;
    logic [32:0] mul_b;
    logic [32:0] div_dividend;
    logic [32:0] div_divisor;
    logic        div_in_valid;

    // Results and status towards EXE
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        md_done;
    logic        md_busy;

    // Controller state, exposed for debug and checkers
    logic [2:0]  state_dbg;

    modport slave (
        input  exe_valid, op_mult, op_div, op_unsigned, src1, src2, flush, accept,
        input  mul_product, div_quotient, div_remainder, div_dout_valid,
        output mul_a, mul_b, div_dividend, div_divisor, div_in_valid,
        output hi_out, lo_out, md_done, md_busy, state_dbg
    );

    modport master (
        output exe_valid, op_mult, op_div, op_unsigned, src1, src2, flush, accept,
        output mul_product, div_quotient, div_remainder, div_dout_valid,
        input  mul_a, mul_b, div_dividend, div_divisor, div_in_valid,
        input  hi_out, lo_out, md_done, md_busy, state_dbg
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the EXE stage.
// Latches sign- or zero-extended 33-bit operands for an external multiplier
// (fixed latency MULT_LAT) or divider (variable latency, handshake). It
// collects the result into hi/lo and holds it until EXE accepts it. An EXE
// flush cancels a multiply at once. A divide cannot be aborted, so a flushed
// divide drains its result before the block is idle again.
// MULT_LAT is meaningful in the range 2..15, and CNT_W must hold MULT_LAT-1.
module muldiv_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int CNT_W    = 4
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_RUN   = 3'd1,
        DIV_ISSUE = 3'd2,
        DIV_WAIT  = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Counter value seen at the edge on which the multiplier product is valid.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [32:0]        mul_a_q;
    logic [32:0]        mul_b_q;
    logic [32:0]        div_dividend_q;
    logic [32:0]        div_divisor_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic               div_in_valid_q;

    logic               req_op;
    logic               start;
    logic               busy_state;

    // A start can only be taken in IDLE, so DONE+accept never overlaps a start.
    assign req_op = bus.op_mult | bus.op_div;
    assign start  = (state == IDLE) & bus.exe_valid & req_op & ~bus.flush;

    // Signed operations extend with bit 31. Unsigned operations extend with zero.
    function automatic logic [32:0] ext33(input logic [31:0] v, input logic is_unsigned);
        return {~is_unsigned & v[31], v};
    endfunction

    // Main sequencer: state, latency counter, operand and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            div_in_valid_q <= 1'b0;
        end else begin
            // The operand pulse is high only for the single DIV_ISSUE cycle.
            div_in_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (bus.op_mult) begin
                            // Multiply has priority when both ops are decoded.
                            mul_a_q <= ext33(bus.src1, bus.op_unsigned);
                            mul_b_q <= ext33(bus.src2, bus.op_unsigned);
                            cnt     <= '0;
                            state   <= MUL_RUN;
                        end else begin
                            div_dividend_q <= ext33(bus.src1, bus.op_unsigned);
                            div_divisor_q  <= ext33(bus.src2, bus.op_unsigned);
                            div_in_valid_q <= 1'b1;
                            state          <= DIV_ISSUE;
                        end
                    end
                end
                MUL_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        hi_q  <= bus.mul_product[63:32];
                        lo_q  <= bus.mul_product[31:0];
                        state <= DONE;
                    end
                end
                DIV_ISSUE: begin
                    // The operand pulse is already on the wire. A flush here
                    // only means the result must be drained.
                    state <= bus.flush ? DRAIN : DIV_WAIT;
                end
                DIV_WAIT: begin
                    if (bus.div_dout_valid) begin
                        if (bus.flush) begin
                            // The result arrives as the instruction is cancelled.
                            state <= IDLE;
                        end else begin
                            lo_q  <= bus.div_quotient;
                            hi_q  <= bus.div_remainder;
                            state <= DONE;
                        end
                    end else if (bus.flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.div_dout_valid) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (bus.flush | bus.accept) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall EXE while any operation or drain is in flight, including the start cycle.
    always_comb begin
        busy_state = 1'b0;
        case (state)
            MUL_RUN, DIV_ISSUE, DIV_WAIT, DRAIN: busy_state = 1'b1;
            default:                             busy_state = 1'b0;
        endcase
    end

    assign bus.md_busy      = ~reset & (busy_state | start);
    assign bus.md_done      = (state == DONE);
    assign bus.state_dbg    = state;
    assign bus.mul_a        = mul_a_q;
    assign bus.mul_b        = mul_b_q;
    assign bus.div_dividend = div_dividend_q;
    assign bus.div_divisor  = div_divisor_q;
    assign bus.div_in_valid = div_in_valid_q;
    assign bus.hi_out       = hi_q;
    assign bus.lo_out       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with MULT_LAT = 5.
// Multiplier: combinational 33x33 signed product model.
// Divider: variable-latency model driven from div_in_valid.
module tb_muldiv_ctrl;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_MUL_RUN   = 3'd1;
    localparam logic [2:0] S_DIV_ISSUE = 3'd2;
    localparam logic [2:0] S_DIV_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.MULT_LAT(5), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- multiplier model ----------------
    logic [63:0] ma_ext;
    logic [63:0] mb_ext;
    assign ma_ext          = {{31{bus.mul_a[32]}}, bus.mul_a};
    assign mb_ext          = {{31{bus.mul_b[32]}}, bus.mul_b};
    assign bus.mul_product = ma_ext * mb_ext;

    // ---------------- divider model ----------------
    int                 div_lat;
    int                 div_cnt;
    int                 div_pulses;
    logic signed [32:0] dd_cap;
    logic signed [32:0] dv_cap;
    logic signed [32:0] q_tmp;
    logic signed [32:0] r_tmp;

    initial begin
        bus.div_dout_valid = 1'b0;
        bus.div_quotient   = '0;
        bus.div_remainder  = '0;
        div_cnt            = 0;
        div_pulses         = 0;
        div_lat            = 5;
    end

    // Sample just after each rising edge so the DUT outputs have settled.
    always @(posedge clk) begin
        #2;
        bus.div_dout_valid = 1'b0;
        if (div_cnt > 0) begin
            div_cnt = div_cnt - 1;
            if (div_cnt == 0) begin
                if (dv_cap == 0) begin
                    q_tmp = '1;
                    r_tmp = dd_cap;
                end else begin
                    q_tmp = dd_cap / dv_cap;
                    r_tmp = dd_cap % dv_cap;
                end
                bus.div_quotient   = q_tmp[31:0];
                bus.div_remainder  = r_tmp[31:0];
                bus.div_dout_valid = 1'b1;
            end
        end
        if (bus.div_in_valid === 1'b1) begin
            div_pulses = div_pulses + 1;
            dd_cap     = bus.div_dividend;
            dv_cap     = bus.div_divisor;
            div_cnt    = div_lat;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic drive_req(input logic m, input logic d, input logic u,
                             input logic [31:0] a, input logic [31:0] b);
        bus.exe_valid   = 1'b1;
        bus.op_mult     = m;
        bus.op_div      = d;
        bus.op_unsigned = u;
        bus.src1        = a;
        bus.src2        = b;
    endtask

    task automatic idle_req();
        bus.exe_valid = 1'b0;
        bus.op_mult   = 1'b0;
        bus.op_div    = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int g;
        g = 0;
        while (bus.md_done !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (bus.md_done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_timeout: md_done=%b required 1", nm, bus.md_done);
        end
    endtask

    task automatic wait_dout(input string nm);
        int g;
        g = 0;
        while (bus.div_dout_valid !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (bus.div_dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_dout_timeout: div_dout_valid=%b required 1", nm, bus.div_dout_valid);
        end
    endtask

    task automatic do_accept();
        bus.accept = 1'b1;
        @(negedge clk);
        bus.accept = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (bus.state_dbg !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d required %0d", bus.state_dbg, S_IDLE); end
        n_cmp++; if (bus.md_done !== 1'b0) begin n_bad++; $display("FAIL reset_md_done: got %b required 0", bus.md_done); end
        n_cmp++; if (bus.md_busy !== 1'b0) begin n_bad++; $display("FAIL reset_md_busy: got %b required 0", bus.md_busy); end
        n_cmp++; if ({bus.hi_out, bus.lo_out} !== 64'h0) begin n_bad++; $display("FAIL reset_hilo: got %h required 0", {bus.hi_out, bus.lo_out}); end
        n_cmp++; if (bus.mul_a !== 33'h0 || bus.div_dividend !== 33'h0) begin n_bad++; $display("FAIL reset_operands: got %h/%h required 0/0", bus.mul_a, bus.div_dividend); end
        reset = 1'b0;
    endtask

    task automatic test_signed_mult();
        @(negedge clk);
        drive_req(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3);
        #1;
        n_cmp++; if (bus.md_busy !== 1'b1) begin n_bad++; $display("FAIL smul_busy_start: got %b required 1", bus.md_busy); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                idle_req();
                n_cmp++; if (bus.mul_a !== 33'h1_FFFF_FFFE) begin n_bad++; $display("FAIL smul_mul_a: got %h required 1fffffffe", bus.mul_a); end
                n_cmp++; if (bus.mul_b !== 33'h0_0000_0003) begin n_bad++; $display("FAIL smul_mul_b: got %h required 3", bus.mul_b); end
                n_cmp++; if (bus.state_dbg !== S_MUL_RUN) begin n_bad++; $display("FAIL smul_state: got %0d required %0d", bus.state_dbg, S_MUL_RUN); end
            end
            n_cmp++; if (bus.md_done !== 1'b0) begin n_bad++; $display("FAIL smul_early_done_c%0d: got %b required 0", c, bus.md_done); end
        end
        @(negedge clk);
        n_cmp++; if (bus.md_done !== 1'b1) begin n_bad++; $display("FAIL smul_done_lat: got %b required 1", bus.md_done); end
        n_cmp++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL smul_hi: got %h required ffffffff", bus.hi_out); end
        n_cmp++; if (bus.lo_out !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL smul_lo: got %h required fffffffa", bus.lo_out); end
        do_accept();
        n_cmp++; if (bus.state_dbg !== S_IDLE || bus.md_done !== 1'b0) begin n_bad++; $display("FAIL smul_accept: state %0d done %b required 0/0", bus.state_dbg, bus.md_done); end
    endtask

    task automatic test_unsigned_div();
        int p0;
        p0      = div_pulses;
        div_lat = 20;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
        @(negedge clk);
        idle_req();
        n_cmp++; if (bus.state_dbg !== S_DIV_ISSUE || bus.div_in_valid !== 1'b1) begin n_bad++; $display("FAIL udiv_issue: state %0d in_valid %b required 2/1", bus.state_dbg, bus.div_in_valid); end
        n_cmp++; if (bus.div_dividend !== 33'd100 || bus.div_divisor !== 33'd7) begin n_bad++; $display("FAIL udiv_operands: got %h/%h required 64/7", bus.div_dividend, bus.div_divisor); end
        @(negedge clk);
        n_cmp++; if (bus.state_dbg !== S_DIV_WAIT || bus.div_in_valid !== 1'b0) begin n_bad++; $display("FAIL udiv_wait: state %0d in_valid %b required 3/0", bus.state_dbg, bus.div_in_valid); end
        wait_dout("udiv");
        n_cmp++; if (bus.md_done !== 1'b0 || bus.md_busy !== 1'b1) begin n_bad++; $display("FAIL udiv_at_dout: done %b busy %b required 0/1", bus.md_done, bus.md_busy); end
        @(negedge clk);
        n_cmp++; if (bus.md_done !== 1'b1) begin n_bad++; $display("FAIL udiv_done: got %b required 1", bus.md_done); end
        n_cmp++; if (bus.lo_out !== 32'd14 || bus.hi_out !== 32'd2) begin n_bad++; $display("FAIL udiv_result: lo %0d hi %0d required 14/2", bus.lo_out, bus.hi_out); end
        n_cmp++; if (div_pulses !== p0 + 1) begin n_bad++; $display("FAIL udiv_pulses: got %0d required %0d", div_pulses - p0, 1); end
        do_accept();
    endtask

    task automatic test_signed_div();
        div_lat = 3;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        idle_req();
        n_cmp++; if (bus.div_dividend !== 33'h1_FFFF_FFF9) begin n_bad++; $display("FAIL sdiv_dividend: got %h required 1fffffff9", bus.div_dividend); end
        wait_done("sdiv");
        n_cmp++; if (bus.lo_out !== 32'hFFFF_FFFD || bus.hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sdiv_result: lo %h hi %h required fffffffd/ffffffff", bus.lo_out, bus.hi_out); end
        do_accept();
    endtask

    task automatic test_done_hold();
        @(negedge clk);
        // Both ops decoded: multiply must win.
        drive_req(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'd2);
        @(negedge clk);
        idle_req();
        n_cmp++; if (bus.state_dbg !== S_MUL_RUN || bus.div_in_valid !== 1'b0) begin n_bad++; $display("FAIL prio_state: state %0d in_valid %b required 1/0", bus.state_dbg, bus.div_in_valid); end
        wait_done("hold");
        for (int c = 0; c < 3; c++) begin
            bus.src1 = 32'h1234_5678;
            @(negedge clk);
            n_cmp++; if (bus.md_done !== 1'b1 || bus.hi_out !== 32'd1 || bus.lo_out !== 32'd0) begin n_bad++; $display("FAIL hold_c%0d: done %b hi %h lo %h required 1/1/0", c, bus.md_done, bus.hi_out, bus.lo_out); end
        end
        // A new request during the accept cycle must not be started.
        drive_req(1'b1, 1'b0, 1'b0, 32'd5, 32'd6);
        bus.accept = 1'b1;
        @(negedge clk);
        bus.accept = 1'b0;
        idle_req();
        n_cmp++; if (bus.state_dbg !== S_IDLE || bus.md_done !== 1'b0) begin n_bad++; $display("FAIL hold_accept: state %0d done %b required 0/0", bus.state_dbg, bus.md_done); end
        n_cmp++; if (bus.mul_a !== 33'h0_8000_0000) begin n_bad++; $display("FAIL hold_no_start: mul_a %h required 080000000", bus.mul_a); end
    endtask

    task automatic test_flush_start();
        @(negedge clk);
        drive_req(1'b1, 1'b0, 1'b0, 32'd5, 32'd6);
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.md_busy !== 1'b0) begin n_bad++; $display("FAIL fstart_busy: got %b required 0", bus.md_busy); end
        @(negedge clk);
        bus.flush = 1'b0;
        idle_req();
        n_cmp++; if (bus.state_dbg !== S_IDLE) begin n_bad++; $display("FAIL fstart_state: got %0d required 0", bus.state_dbg); end
        n_cmp++; if (bus.mul_a !== 33'h0_8000_0000 || bus.mul_b !== 33'd2) begin n_bad++; $display("FAIL fstart_operands: got %h/%h required 080000000/2", bus.mul_a, bus.mul_b); end
    endtask

    task automatic test_flush_div_wait();
        int p0;
        p0      = div_pulses;
        div_lat = 8;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 32'd50, 32'd5);
        @(negedge clk);
        idle_req();
        @(negedge clk);
        n_cmp++; if (bus.state_dbg !== S_DIV_WAIT) begin n_bad++; $display("FAIL fdiv_wait: got %0d required 3", bus.state_dbg); end
        // Flush, with the next divide already waiting in EXE.
        bus.flush = 1'b1;
        drive_req(1'b0, 1'b1, 1'b1, 32'd9, 32'd2);
        @(negedge clk);
        bus.flush = 1'b0;
        n_cmp++; if (bus.state_dbg !== S_DRAIN) begin n_bad++; $display("FAIL fdiv_drain: got %0d required 4", bus.state_dbg); end
        while (bus.div_dout_valid !== 1'b1 && bus.state_dbg == S_DRAIN) begin
            n_cmp++; if (bus.md_done !== 1'b0 || bus.md_busy !== 1'b1) begin n_bad++; $display("FAIL fdiv_drain_busy: done %b busy %b required 0/1", bus.md_done, bus.md_busy); end
            @(negedge clk);
        end
        n_cmp++; if (bus.div_dout_valid !== 1'b1 || bus.state_dbg !== S_DRAIN) begin n_bad++; $display("FAIL fdiv_dout_in_drain: dout %b state %0d required 1/4", bus.div_dout_valid, bus.state_dbg); end
        @(negedge clk);
        n_cmp++; if (bus.state_dbg !== S_IDLE || bus.md_busy !== 1'b1 || bus.md_done !== 1'b0) begin n_bad++; $display("FAIL fdiv_idle_pending: state %0d busy %b done %b required 0/1/0", bus.state_dbg, bus.md_busy, bus.md_done); end
        @(negedge clk);
        idle_req();
        n_cmp++; if (bus.state_dbg !== S_DIV_ISSUE) begin n_bad++; $display("FAIL fdiv_second_issue: got %0d required 2", bus.state_dbg); end
        wait_done("fdiv");
        n_cmp++; if (bus.lo_out !== 32'd4 || bus.hi_out !== 32'd1) begin n_bad++; $display("FAIL fdiv_result: lo %0d hi %0d required 4/1", bus.lo_out, bus.hi_out); end
        n_cmp++; if (div_pulses !== p0 + 2) begin n_bad++; $display("FAIL fdiv_pulses: got %0d required 2", div_pulses - p0); end
        do_accept();
    endtask

    task automatic test_reset_mid_mult();
        @(negedge clk);
        drive_req(1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
        @(negedge clk);
        idle_req();
        @(negedge clk);
        n_cmp++; if (bus.state_dbg !== S_MUL_RUN) begin n_bad++; $display("FAIL rmul_running: got %0d required 1", bus.state_dbg); end
        // Assert reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.state_dbg !== S_IDLE) begin n_bad++; $display("FAIL rmul_state: got %0d required 0", bus.state_dbg); end
        n_cmp++; if (bus.mul_a !== 33'h0 || bus.mul_b !== 33'h0 || bus.div_dividend !== 33'h0 || bus.div_divisor !== 33'h0) begin n_bad++; $display("FAIL rmul_operands: %h %h %h %h required 0", bus.mul_a, bus.mul_b, bus.div_dividend, bus.div_divisor); end
        n_cmp++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin n_bad++; $display("FAIL rmul_hilo: hi %h lo %h required 0/0", bus.hi_out, bus.lo_out); end
        n_cmp++; if (bus.md_done !== 1'b0 || bus.md_busy !== 1'b0 || bus.div_in_valid !== 1'b0) begin n_bad++; $display("FAIL rmul_flags: done %b busy %b in_valid %b required 0/0/0", bus.md_done, bus.md_busy, bus.div_in_valid); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        div_lat = 6;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b1, 32'd20, 32'd3);
        @(negedge clk);
        idle_req();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_dout("rdiv");
        @(negedge clk);
        n_cmp++; if (bus.state_dbg !== S_IDLE || bus.md_done !== 1'b0 || bus.md_busy !== 1'b0) begin n_bad++; $display("FAIL rdiv_ignored: state %0d done %b busy %b required 0/0/0", bus.state_dbg, bus.md_done, bus.md_busy); end
        n_cmp++; if (bus.lo_out !== 32'h0 || bus.hi_out !== 32'h0) begin n_bad++; $display("FAIL rdiv_hilo: lo %h hi %h required 0/0", bus.lo_out, bus.hi_out); end
    endtask

    // ---------------- sequence ----------------
    initial begin
        n_cmp           = 0;
        n_bad           = 0;
        reset           = 1'b1;
        bus.exe_valid   = 1'b0;
        bus.op_mult     = 1'b0;
        bus.op_div      = 1'b0;
        bus.op_unsigned = 1'b0;
        bus.src1        = '0;
        bus.src2        = '0;
        bus.flush       = 1'b0;
        bus.accept      = 1'b0;
        test_reset();
        test_signed_mult();
        test_unsigned_div();
        test_signed_div();
        test_done_hold();
        test_flush_start();
        test_flush_div_wait();
        test_reset_mid_mult();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5, meaning cycles from operand latch to a valid multiplier product (legal range 2..15).
REQ-002 SHALL have parameter CNT_W, default 4, meaning the multiply latency counter width.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port exe_valid  in  1  EXE stage holds a valid instruction.
REQ-006 SHALL have ports op_mult, op_div, op_unsigned  in  1 each  operation decode.
REQ-007 SHALL have ports src1, src2  in  32 each  operands (dividend/multiplicand = src1).
REQ-008 SHALL have port flush  in  1  exception/eret cancel of EXE.
REQ-009 SHALL have port accept  in  1  downstream takes the result.
REQ-010 SHALL have port mul_product  in  64  multiplier output, low 64 bits.
REQ-011 SHALL have ports div_quotient, div_remainder  in  32 each, and div_dout_valid  in  1, the divider result handshake.
REQ-012 SHALL have ports mul_a, mul_b, div_dividend, div_divisor  out  33 each  registered operands.
REQ-013 SHALL have port div_in_valid  out  1  divider operand-valid pulse.
REQ-014 SHALL have ports hi_out, lo_out  out  32 each, plus md_done and md_busy  out  1 each.

Function
REQ-015 SHALL implement states IDLE, MUL_RUN, DIV_ISSUE, DIV_WAIT, DRAIN and DONE.
REQ-016 SHALL define start = exe_valid & (op_mult|op_div) & ~flush, sampled only in IDLE; op_mult wins when both ops are set.
REQ-017 SHALL, on start, latch {ext,src} into the 33-bit operand registers, where ext = op_unsigned ? 0 : src[31].
REQ-018 SHALL hold the operand registers stable until the next start.
REQ-019 SHALL, on a mult start, clear the counter and go to MUL_RUN.
REQ-020 SHALL, in MUL_RUN, increment the counter each cycle and, at the edge after count == MULT_LAT-1, latch hi = mul_product[63:32] and lo = [31:0] and go to DONE.
REQ-021 SHALL raise md_done exactly MULT_LAT cycles after the start edge.
REQ-022 SHALL, on a div start, go to DIV_ISSUE, where div_in_valid = 1 for exactly one cycle, then go to DIV_WAIT.
REQ-023 SHALL, in DIV_WAIT, on div_dout_valid latch lo = div_quotient and hi = div_remainder and go to DONE.
REQ-024 SHALL give divide-by-zero no special handling; the IP result is passed through.
REQ-025 SHALL, in DONE, hold md_done = 1 and hi_out/lo_out stable; accept returns the block to IDLE.
REQ-026 SHALL not sample a new start in the same cycle as accept.
REQ-027 SHALL, on flush in MUL_RUN or DONE, go to IDLE with no result update.
REQ-028 SHALL, on flush in DIV_ISSUE or DIV_WAIT, go to DRAIN (the divider cannot abort); the DIV_ISSUE pulse still completes.
REQ-029 SHALL, in DRAIN, discard the result on div_dout_valid and go to IDLE; md_done is never raised.
REQ-030 SHALL ignore div_dout_valid in IDLE, MUL_RUN and DONE.
REQ-031 SHALL compute md_busy = state in {MUL_RUN, DIV_ISSUE, DIV_WAIT, DRAIN} | (IDLE & start), combinationally, to stall EXE.
REQ-032 SHALL keep md_busy high through DRAIN; a pending request starts on the first IDLE cycle.
REQ-033 SHALL drive md_done = (state == DONE), registered-state decode.

Reset
REQ-034 SHALL, while reset is high, immediately force state IDLE, counter 0, operands 0, hi_out/lo_out 0, div_in_valid 0, md_done 0 and md_busy 0, independent of clk.
REQ-035 SHALL, after reset deasserts mid-operation, lose the old operation; any in-flight divider result then arrives in IDLE and is ignored.

Verification
REQ-036 SHALL cover signed mult: src1 = 0xFFFFFFFE, src2 = 3, product model = -6 -> mul_a = 0x1FFFFFFFE; md_done 5 cycles after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
REQ-037 SHALL cover unsigned div: 100/7, IP latency 20 -> a single div_in_valid pulse; md_done the cycle after div_dout_valid; lo = 14, hi = 2.
REQ-038 SHALL cover flush in DIV_WAIT: no md_done; md_busy held until dout; a second div 9/2 then yields lo = 4, hi = 1.
REQ-039 SHALL cover DONE hold: accept low for 3 cycles -> md_done and hi/lo stable; accept high -> IDLE next cycle.
REQ-040 SHALL cover flush at the start cycle: state stays IDLE, operands unchanged, md_busy 0.
REQ-041 SHALL cover reset in MUL_RUN cycle 2: all outputs 0 immediately, without waiting for a clk edge.
